// File: rtl/switch_matrix_cfg.sv
// Configurable pin switch matrix with shadow/active config banks.
// Optional registered readback of the active bank: SWM_READBACK_EN.
module switch_matrix_cfg #(
   parameter  int NT = 5,
   parameter  int NS = 4,
   localparam int MX = (NT > NS) ? NT : NS,
   localparam int IW = $clog2(MX),
   localparam int EW = IW + 3,
   localparam int N  = 2*NT + 2*NS,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   inout  wire  [NT-1:0] wtop,
   inout  wire  [NT-1:0] wbottom,
   inout  wire  [NS-1:0] wleft,
   inout  wire  [NS-1:0] wright,
   input  logic          cfg_valid,
   input  logic [AW-1:0] cfg_addr,
   input  logic [EW-1:0] cfg_data,
   input  logic          cfg_commit,
   input  logic          cfg_clear,
   output logic          cfg_ready,
   output logic          cfg_err,
   output logic          commit_done
`ifdef SWM_READBACK_EN
   ,
   output logic [EW-1:0] cfg_rdata
`endif
);

   localparam int PW = 1 << IW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMMIT,
      S_CLEAR
   } state_t;

   state_t r_state;
   state_t w_nxt;

   logic [EW-1:0] r_shd [N];
   logic [EW-1:0] r_act [N];
   logic [AW-1:0] r_cnt;
   logic          r_err;
   logic          r_done;
   logic          w_inrng;
   logic          w_wr;
   logic          w_bad;
   logic          w_last;

   // Returns {drive enable, source value} for one pin's entry.
   function automatic logic [1:0] f_route(
      input logic [EW-1:0] e,
      input logic [2:0]    own,
      input logic [IW-1:0] self,
      input logic [NT-1:0] t,
      input logic [NT-1:0] b,
      input logic [NS-1:0] l,
      input logic [NS-1:0] r
   );
      logic [PW-1:0] v;
      logic [2:0]    c;
      logic [IW-1:0] ix;
      int            w;
      logic          ok;
      v  = '0;
      w  = 0;
      c  = e[2:0];
      ix = e[EW-1:3];
      case (c)
         3'd1: begin v[NT-1:0] = t; w = NT; end
         3'd2: begin v[NS-1:0] = r; w = NS; end
         3'd3: begin v[NT-1:0] = b; w = NT; end
         3'd4: begin v[NS-1:0] = l; w = NS; end
         default: w = 0;
      endcase
      ok = (int'(ix) < w) && !((c == own) && (ix == self));
      return {ok, v[ix]};
   endfunction

   for (genvar i = 0; i < NT; i++) begin : g_top
      logic [1:0] w_rt;
      assign w_rt = f_route(r_act[i], 3'd1, IW'(i),
                            wtop, wbottom, wleft, wright);
      assign wtop[i] = w_rt[1] ? w_rt[0] : 1'bz;
   end

   for (genvar i = 0; i < NT; i++) begin : g_bot
      logic [1:0] w_rt;
      assign w_rt = f_route(r_act[NT+i], 3'd3, IW'(i),
                            wtop, wbottom, wleft, wright);
      assign wbottom[i] = w_rt[1] ? w_rt[0] : 1'bz;
   end

   for (genvar i = 0; i < NS; i++) begin : g_left
      logic [1:0] w_rt;
      assign w_rt = f_route(r_act[2*NT+i], 3'd4, IW'(i),
                            wtop, wbottom, wleft, wright);
      assign wleft[i] = w_rt[1] ? w_rt[0] : 1'bz;
   end

   for (genvar i = 0; i < NS; i++) begin : g_right
      logic [1:0] w_rt;
      assign w_rt = f_route(r_act[2*NT+NS+i], 3'd2, IW'(i),
                            wtop, wbottom, wleft, wright);
      assign wright[i] = w_rt[1] ? w_rt[0] : 1'bz;
   end

   assign cfg_ready   = (r_state == S_IDLE);
   assign cfg_err     = r_err;
   assign commit_done = r_done;

   assign w_inrng = (int'(cfg_addr) < N);
   assign w_wr    = cfg_ready & cfg_valid & w_inrng;
   assign w_bad   = cfg_ready & cfg_valid & ~w_inrng;
   assign w_last  = (int'(r_cnt) == N - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (cfg_clear)       w_nxt = S_CLEAR;
            else if (cfg_commit) w_nxt = S_COMMIT;
         end
         S_COMMIT: w_nxt = S_IDLE;
         S_CLEAR:  if (w_last) w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            r_shd[i] <= '0;
            r_act[i] <= '0;
         end
         r_cnt  <= '0;
         r_err  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_err  <= w_bad;
         r_done <= (r_state == S_COMMIT);
         if (w_wr) r_shd[cfg_addr] <= cfg_data;
         // Whole-bank copy so routing never sees a partial update.
         if (r_state == S_COMMIT) r_act <= r_shd;
         if (r_state == S_CLEAR) begin
            r_shd[r_cnt] <= '0;
            r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

`ifdef SWM_READBACK_EN
   logic [EW-1:0] r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_rdata <= '0;
      else if (w_inrng) r_rdata <= r_act[cfg_addr];
      else              r_rdata <= '0;
   end

   assign cfg_rdata = r_rdata;
`endif

endmodule

// File: tb/tb_switch_matrix_cfg.sv
// Directed bench for switch_matrix_cfg (NT=5, NS=4).
// Pin state is read as "driven high" per pin, with wleft[2] as the source.
module tb_switch_matrix_cfg;

   localparam int NT = 5;
   localparam int NS = 4;
   localparam int EW = 6;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic [AW-1:0] cfg_addr;
   logic [EW-1:0] cfg_data;
   logic          cfg_commit;
   logic          cfg_clear;
   logic          cfg_ready;
   logic          cfg_err;
   logic          commit_done;
`ifdef SWM_READBACK_EN
   logic [EW-1:0] cfg_rdata;
`endif

   wire  [NT-1:0] wtop;
   wire  [NT-1:0] wbottom;
   wire  [NS-1:0] wleft;
   wire  [NS-1:0] wright;

   logic tb_en;
   logic tb_val;

   int n_vec = 0;
   int n_err = 0;

   assign wleft[2] = tb_en ? tb_val : 1'bz;

   always #5 clk = ~clk;

   switch_matrix_cfg #(.NT(NT), .NS(NS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wtop        (wtop),
      .wbottom     (wbottom),
      .wleft       (wleft),
      .wright      (wright),
      .cfg_valid   (cfg_valid),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_commit  (cfg_commit),
      .cfg_clear   (cfg_clear),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .commit_done (commit_done)
`ifdef SWM_READBACK_EN
      ,
      .cfg_rdata   (cfg_rdata)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Bit a is 1 when the pin at entry address a reads high.
   function automatic logic [17:0] ones();
      logic [17:0] p;
      logic [17:0] v;
      p = {wright, wleft, wbottom, wtop};
      for (int b = 0; b < 18; b++) v[b] = (p[b] === 1'b1);
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [EW-1:0] d);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic do_commit(input string tag);
      cfg_commit = 1'b1;
      cyc();
      cfg_commit = 1'b0;
      cyc();
      chk(tag, commit_done, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int dn;
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      cfg_commit = 1'b0;
      cfg_clear  = 1'b0;
      tb_en      = 1'b1;
      tb_val     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", cfg_ready, 1);
      chk("rst_pins", ones(), 18'h01000);
      rst_n = 1'b1;
      cyc();
      chk("ready", cfg_ready, 1);
      chk("err0", cfg_err, 0);
      chk("done0", commit_done, 0);
      chk("pins0", ones(), 18'h01000);
`ifdef SWM_READBACK_EN
      chk("rb_rst", cfg_rdata, 0);
`endif

      wr(5'd0, 6'h14);
      chk("wr_shadow", ones(), 18'h01000);
      cfg_commit = 1'b1;
      cyc();
      cfg_commit = 1'b0;
      chk("c_busy", cfg_ready, 0);
      chk("c_e1_done", commit_done, 0);
      chk("c_e1_pins", ones(), 18'h01000);
      cyc();
      chk("c_done", commit_done, 1);
      chk("c_pins", ones(), 18'h01001);
      chk("c_ready", cfg_ready, 1);
      cyc();
      chk("c_done_off", commit_done, 0);
      tb_val = 1'b0;
      #1 chk("follow0", ones(), 18'h00000);
      tb_val = 1'b1;
      #1 chk("follow1", ones(), 18'h01001);
`ifdef SWM_READBACK_EN
      cfg_addr = 5'd0;
      cyc();
      chk("rb0", cfg_rdata, 6'h14);
      cfg_addr = 5'd20;
      cyc();
      chk("rb_oor", cfg_rdata, 0);
`endif

      wr(5'd18, 6'h14);
      chk("err_pulse", cfg_err, 1);
      cyc();
      chk("err_off", cfg_err, 0);
      do_commit("bad_cdone");
      chk("bad_nochg", ones(), 18'h01001);

      wr(5'd11, 6'h01);
      wr(5'd7,  6'h0C);
      wr(5'd17, 6'h13);
      wr(5'd16, 6'h21);
      wr(5'd15, 6'h29);
      wr(5'd14, 6'h2C);
      wr(5'd1,  6'h09);
      wr(5'd13, 6'h05);
      cfg_valid  = 1'b1;
      cfg_addr   = 5'd4;
      cfg_data   = 6'h1A;
      cfg_commit = 1'b1;
      cyc();
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      cyc();
      chk("chain_done", commit_done, 1);
      chk("chain", ones(), 18'h31891);
      tb_val = 1'b0;
      #1 chk("chain0", ones(), 18'h00000);
      tb_val = 1'b1;
      #1;

      cfg_clear  = 1'b1;
      cfg_commit = 1'b1;
      cyc();
      cfg_clear = 1'b0;
      cfg_valid = 1'b1;
      cfg_addr  = 5'd3;
      cfg_data  = 6'h14;
      n  = 0;
      dn = 0;
      while (!cfg_ready && n < 40) begin
         n++;
         if (commit_done) dn++;
         if (n == 5) chk("clr_route", ones(), 18'h31891);
         cyc();
      end
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      chk("clr_len", n, 18);
      chk("clr_nodone", dn, 0);
      do_commit("clr_cdone");
      chk("clr_pins", ones(), 18'h01000);

      wr(5'd0, 6'h14);
      wr(5'd17, 6'h14);
      do_commit("pre_cdone");
      chk("pre_pins", ones(), 18'h21001);
      cfg_clear = 1'b1;
      cyc();
      cfg_clear = 1'b0;
      repeat (7) cyc();
      rst_n = 1'b0;
      #1;
      chk("mid_ready", cfg_ready, 1);
      chk("mid_pins", ones(), 18'h01000);
      chk("mid_done", commit_done, 0);
`ifdef SWM_READBACK_EN
      chk("mid_rb", cfg_rdata, 0);
`endif
      #2 rst_n = 1'b1;
      cyc();
      chk("post_ready", cfg_ready, 1);
      do_commit("post_cdone");
      chk("post_shadow", ones(), 18'h01000);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
